// File: rtl/fifo_pkg.sv
// Shared constants and pointer arithmetic for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEEPWID_DEF = 3;
    localparam int unsigned DATAWID_DEF = 8;

    // Increment an extended pointer of ptr_w bits, wrapping to zero after all-ones.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (ptr_w >= 32) ? '1 : ((32'd1 << ptr_w) - 32'd1);
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// One extended (lap-bit) FIFO pointer: advances by one when enabled, clears on reset.
module fifo_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_W = DEEPWID_DEF + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [PTR_W-1:0] cnt_o
);

    logic [PTR_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  cnt_d;
    logic [31:0]       inc_full;
    logic [31-PTR_W:0] unused_inc_hi;

    assign inc_full      = ptr_inc(32'(cnt_q), PTR_W);
    assign unused_inc_hi = inc_full[31:PTR_W];
    assign cnt_d         = en_i ? inc_full[PTR_W-1:0] : cnt_q;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO request gating, write/read pointer control, read-valid tracking and sticky errors.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEEPWID = DEEPWID_DEF,
    parameter int unsigned DATAWID = DATAWID_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req,
    input  logic [DATAWID-1:0] wr_data,
    input  logic               rd_req,
    input  logic               full,
    input  logic               empty,
    input  logic               err_clr,
    output logic               ram_wr_en,
    output logic [DEEPWID-1:0] ram_wr_addr,
    output logic [DATAWID-1:0] ram_wr_data,
    output logic               ram_rd_en,
    output logic [DEEPWID-1:0] ram_rd_addr,
    output logic [DEEPWID:0]   wr_addr,
    output logic [DEEPWID:0]   rd_addr,
    output logic               rd_valid,
    output logic               overflow,
    output logic               underflow
);

    logic rd_valid_q, rd_valid_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Flags reflect pre-edge pointers, so a same-cycle pop never frees room for a push.
    assign ram_wr_en   = wr_req & ~full;
    assign ram_rd_en   = rd_req & ~empty;
    assign ram_wr_data = wr_data;

    fifo_ptr_cnt #(.PTR_W(DEEPWID + 1)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ram_wr_en),
        .cnt_o (wr_addr)
    );

    fifo_ptr_cnt #(.PTR_W(DEEPWID + 1)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ram_rd_en),
        .cnt_o (rd_addr)
    );

    assign ram_wr_addr = wr_addr[DEEPWID-1:0];
    assign ram_rd_addr = rd_addr[DEEPWID-1:0];

    // A new error event wins over a clear arriving in the same cycle.
    assign rd_valid_d  = ram_rd_en;
    assign overflow_d  = (wr_req & full)  | (overflow_q  & ~err_clr);
    assign underflow_d = (rd_req & empty) | (underflow_q & ~err_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
